ula_arbiter: RTL
================

// Module: ula_arbiter
// PURPOSE
//   Shares one combinational ula (32-bit ALU: A, B, f[2:0] -> saida, v) between two
//   requesters. Round-robin arbitration with valid/ready handshakes.
//   Accepted operands are registered and held stable on the ALU for SETTLE cycles so
//   the ripple carry chain can settle. The result is then captured and returned to
//   the winning requester.
// PARAMETERS
//   WIDTH   32  operand/result width; must match the ula instance
//   SETTLE  2   cycles operands are held on the ALU before capture; legal range 1..15
// PORTS
//   clk         in   1      single clock, rising edge
//   rst         in   1      synchronous reset, active-high
//   req0_valid  in   1      requester 0 presents an operation
//   req0_ready  out  1      arbiter accepts requester 0 this cycle
//   req0_a      in   WIDTH  operand A
//   req0_b      in   WIDTH  operand B
//   req0_f      in   3      ALU function code
//   req1_*      -    -      same set as req0_* for requester 1
//   rsp0_valid  out  1      result for requester 0 is available
//   rsp0_ready  in   1      requester 0 takes the result
//   rsp0_saida  out  WIDTH  result
//   rsp0_v      out  1      overflow flag from the ALU
//   rsp1_*      -    -      same set as rsp0_* for requester 1
//   ula_a       out  WIDTH  to ula A
//   ula_b       out  WIDTH  to ula B
//   ula_f       out  3      to ula f
//   ula_saida   in   WIDTH  from ula saida
//   ula_v       in   1      from ula v
//   busy        out  1      high whenever state != IDLE
// BEHAVIOUR
//   - FSM states are IDLE, EXEC and RESP.
//   - Registers: op_a, op_b, op_f, owner (1b), last_grant (1b), cnt (4b), res, res_v.
//   - Reset: state=IDLE, op_a/op_b/op_f=0, res/res_v=0, cnt=0, last_grant=1.
//     After reset, all rsp*_valid=0, req*_ready=0 and busy=0.
//   - Reset mid-operation: the in-flight op is discarded and no response is issued.
//   - ula_a/ula_b/ula_f = op_a/op_b/op_f at all times. They change only on accept.
//   - Ready is combinational and asserted only in IDLE:
//       req0_ready = IDLE & req0_valid & (!req1_valid | last_grant==1)
//       req1_ready = IDLE & req1_valid & (!req0_valid | last_grant==0)
//   - At most one ready is high per cycle. A lone requester always wins.
//     When both request, the one not granted last wins.
//   - Accept (valid & ready) in IDLE:
//       load op_* from the winner; owner = last_grant = winner;
//       cnt = SETTLE-1; next state is EXEC.
//   - EXEC: if cnt != 0, decrement cnt.
//     If cnt == 0: res = ula_saida, res_v = ula_v, next state is RESP.
//   - RESP: rsp{owner}_valid=1. The other rsp*_valid stays 0.
//     rsp*_saida/rsp*_v = res/res_v (driven to both ports; qualify with valid).
//     The result holds until rsp{owner}_ready=1, then next state is IDLE.
//   - No accept happens in the same cycle as a response handshake.
//     Minimum spacing between accepts is SETTLE+2 cycles.
//   - Latency: with the accept in cycle T, rsp_valid rises in cycle T+SETTLE+1
//     (T+3 at the default).
//   - Backpressure: rsp_ready held low keeps the FSM in RESP indefinitely.
//     Requests stay pending with ready=0; nothing is dropped.
//   - Requesters must hold req*_a/b/f stable while valid=1 and ready=0.
//   - Arithmetic is entirely the ula's. op_f passes through unchanged.
//     ula_v is meaningful only for f=000/001; it is captured and returned as-is.
// TESTING
//   1. rst held 3 cycles with both valids high
//      -> every ready/valid=0, busy=0, ula_a=ula_b=0.
//   2. Only req0: a=5, b=7, f=000 accepted in cycle T
//      -> rsp0_valid in T+3, rsp0_saida=12, rsp0_v=0; rsp1_valid stays 0.
//   3. Only req1: a=0x7FFFFFFF, b=1, f=000
//      -> rsp1_saida=0x80000000, rsp1_v=1.
//   4. Both valid continuously, each rsp_ready tied 1
//      -> grants alternate 0,1,0,1; first grant goes to req0;
//      accepts are exactly 4 cycles apart.
//   5. rsp0_ready held 0 for 10 cycles while req1 is valid
//      -> rsp0 result holds stable, req1_ready=0 throughout;
//      req1 is accepted the cycle after the rsp0 handshake.
//   6. rst asserted during EXEC
//      -> no rsp*_valid ever appears for that op;
//      the next op completes with the correct result.

Source files
------------

// File: rtl/ula_arbiter_if.sv
// Request/response bundle between two requesters and the shared-ALU arbiter.
// The master modport is the requester side; the slave modport is the arbiter side.
interface ula_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic [2:0]       req0_f;
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic [2:0]       req1_f;

    logic             rsp0_valid;
    logic             rsp0_ready;
    logic [WIDTH-1:0] rsp0_saida;
    logic             rsp0_v;
    logic             rsp1_valid;
    logic             rsp1_ready;
    logic [WIDTH-1:0] rsp1_saida;
    logic             rsp1_v;

    modport master (
        output req0_valid, req0_a, req0_b, req0_f,
        output req1_valid, req1_a, req1_b, req1_f,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_saida, rsp0_v,
        input  rsp1_valid, rsp1_saida, rsp1_v
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_f,
        input  req1_valid, req1_a, req1_b, req1_f,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_saida, rsp0_v,
        output rsp1_valid, rsp1_saida, rsp1_v
    );
endinterface

// File: rtl/ula_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands are held on the ALU for SETTLE cycles, then the result is returned.
module ula_arbiter #(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    ula_arbiter_if.slave     bus,
    output logic [WIDTH-1:0] ula_a,
    output logic [WIDTH-1:0] ula_b,
    output logic [2:0]       ula_f,
    input  logic [WIDTH-1:0] ula_saida,
    input  logic             ula_v,
    output logic             busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [2:0]       op_f_q, op_f_d;
    logic             owner_q, owner_d;
    logic             last_grant_q, last_grant_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             res_v_q, res_v_d;

    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       rsp_ready;
    logic [1:0]       rsp_valid;
    logic [WIDTH-1:0] req_a [2];
    logic [WIDTH-1:0] req_b [2];
    logic [2:0]       req_f [2];
    logic             winner;

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};
    assign req_a[0]  = bus.req0_a;
    assign req_a[1]  = bus.req1_a;
    assign req_b[0]  = bus.req0_b;
    assign req_b[1]  = bus.req1_b;
    assign req_f[0]  = bus.req0_f;
    assign req_f[1]  = bus.req1_f;

    // A requester wins when alone, or when both request and it was not granted last.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign req_ready[gi] = !rst && (state_q == IDLE) && req_valid[gi] &&
                                   (!req_valid[1-gi] || (last_grant_q != 1'(gi)));
            assign rsp_valid[gi] = (state_q == RESP) && (owner_q == 1'(gi));
        end
    endgenerate

    assign winner = req_ready[1];

    always_comb begin
        state_d      = state_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_f_d       = op_f_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        res_d        = res_q;
        res_v_d      = res_v_q;
        case (state_q)
            IDLE: begin
                if (|req_ready) begin
                    op_a_d       = req_a[winner];
                    op_b_d       = req_b[winner];
                    op_f_d       = req_f[winner];
                    owner_d      = winner;
                    last_grant_d = winner;
                    cnt_d        = CNT_INIT;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    res_d   = ula_saida;
                    res_v_d = ula_v;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_f_q       <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            res_q        <= '0;
            res_v_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_f_q       <= op_f_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            res_q        <= res_d;
            res_v_q      <= res_v_d;
        end
    end

    assign ula_a = op_a_q;
    assign ula_b = op_b_q;
    assign ula_f = op_f_q;
    assign busy  = (state_q != IDLE);

    assign bus.req0_ready = req_ready[0];
    assign bus.req1_ready = req_ready[1];
    assign bus.rsp0_valid = rsp_valid[0];
    assign bus.rsp1_valid = rsp_valid[1];
    assign bus.rsp0_saida = res_q;
    assign bus.rsp1_saida = res_q;
    assign bus.rsp0_v     = res_v_q;
    assign bus.rsp1_v     = res_v_q;
endmodule
